i2c_target_regfile: RTL and testbench

//  I2C target (responder) with an internal byte register file; the bus-side counterpart of
//  the i2c_N FPGA I2C masters. Serves as an on-chip loopback target for exercising those masters
//  and as an emulated sensor/config device. The host reads/writes the same registers via a

---
 rtl/i2c_target_regfile.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file shared with a synchronous host port.
// SDA is open-drain (sda_oe=1 pulls low); SCL is never stretched.
module i2c_target_regfile #(
  parameter logic [6:0] I2C_ADDR    = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       host_write,
  output logic [7:0] host_rdata,
  output logic       i2c_wr_pulse,
  output logic [7:0] i2c_wr_addr,
  output logic [7:0] i2c_wr_data,
  output logic       busy
);

  // state    | meaning
  // IDLE     | bus free or not addressed
  // ADDR     | shifting in {address, R/W}
  // ADDR_ACK | driving ACK for our address
  // PTR      | shifting in register pointer
  // PTR_ACK  | driving ACK for pointer byte
  // WDATA    | shifting in write data
  // WACK     | driving ACK for write data
  // RDATA    | driving read data, MSB first
  // MACK     | sampling master ACK/NACK
  // WAIT     | master NACKed a read; released until START/STOP
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WACK, ST_RDATA, ST_MACK, ST_WAIT
  } state_t;

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [FCW-1:0]         scl_cnt, sda_cnt;
  logic                   scl_f, sda_f, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  logic [3:0] bit_cnt;
  logic [7:0] shreg, tx, pointer;
  logic       rw, mack_nack;
  logic [7:0] regs [NUM_REGS];

  logic       shifting, byte_done, addr_hit, ptr_ok, host_ok;
  logic [7:0] rd_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_cnt  <= FCW'(FILTER_LEN - 1);
      sda_cnt  <= FCW'(FILTER_LEN - 1);
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      // Down-counter reloads whenever the synced level agrees with the accepted one.
      if (scl_sync[SYNC_STAGES-1] == scl_f) scl_cnt <= FCW'(FILTER_LEN - 1);
      else if (scl_cnt == '0) begin
        scl_f   <= scl_sync[SYNC_STAGES-1];
        scl_cnt <= FCW'(FILTER_LEN - 1);
      end else scl_cnt <= scl_cnt - 1'b1;
      if (sda_sync[SYNC_STAGES-1] == sda_f) sda_cnt <= FCW'(FILTER_LEN - 1);
      else if (sda_cnt == '0) begin
        sda_f   <= sda_sync[SYNC_STAGES-1];
        sda_cnt <= FCW'(FILTER_LEN - 1);
      end else sda_cnt <= sda_cnt - 1'b1;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_c   = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c    = scl_f & scl_d & ~sda_d & sda_f;
  assign shifting  = (state == ST_ADDR) || (state == ST_PTR) ||
                     (state == ST_WDATA) || (state == ST_RDATA);
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign addr_hit  = (shreg[7:1] == I2C_ADDR);
  assign ptr_ok    = int'(pointer) < NUM_REGS;
  assign host_ok   = int'(host_addr) < NUM_REGS;
  assign rd_val    = ptr_ok ? regs[pointer[IDX_W-1:0]] : 8'hFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stop_c) state_nx = ST_IDLE;
    else if (start_c) state_nx = ST_ADDR;
    else if (scl_fall) begin
      case (state)
        ST_ADDR:     if (byte_done) state_nx = addr_hit ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: state_nx = rw ? ST_RDATA : ST_PTR;
        ST_PTR:      if (byte_done) state_nx = ST_PTR_ACK;
        ST_PTR_ACK:  state_nx = ST_WDATA;
        ST_WDATA:    if (byte_done) state_nx = ST_WACK;
        ST_WACK:     state_nx = ST_WDATA;
        ST_RDATA:    if (byte_done) state_nx = ST_MACK;
        ST_MACK:     state_nx = mack_nack ? ST_WAIT : ST_RDATA;
        default:     state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_addr  <= '0;
      i2c_wr_data  <= '0;
      host_rdata   <= '0;
      pointer      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= '0;
      rw           <= 1'b0;
      mack_nack    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      i2c_wr_pulse <= 1'b0;
      if (start_c || (state_nx != state)) bit_cnt <= '0;
      else if (scl_rise && shifting)      bit_cnt <= bit_cnt + 4'd1;
      if (scl_rise && shifting) shreg <= {shreg[6:0], sda_f};
      if (scl_rise && (state == ST_MACK)) mack_nack <= sda_f;

      if (stop_c) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_c) begin
        sda_oe <= 1'b0;
      end else if (scl_fall) begin
        case (state)
          ST_ADDR: if (bit_cnt == 4'd8) begin
            if (addr_hit) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shreg[0];
            end else busy <= 1'b0;
          end
          ST_ADDR_ACK, ST_MACK: begin
            // Read byte is frozen here so host writes mid-byte do not tear it.
            if ((state == ST_ADDR_ACK) ? rw : !mack_nack) begin
              sda_oe <= ~rd_val[7];
              tx     <= {rd_val[6:0], 1'b1};
            end else sda_oe <= 1'b0;
          end
          ST_PTR: if (bit_cnt == 4'd8) begin
            pointer <= shreg;
            sda_oe  <= 1'b1;
          end
          ST_PTR_ACK, ST_WACK: sda_oe <= 1'b0;
          ST_WDATA: if (bit_cnt == 4'd8) begin
            sda_oe  <= 1'b1;
            pointer <= pointer + 8'd1;
            if (ptr_ok) begin
              regs[pointer[IDX_W-1:0]] <= shreg;
              i2c_wr_pulse <= 1'b1;
              i2c_wr_addr  <= pointer;
              i2c_wr_data  <= shreg;
            end
          end
          ST_RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              pointer <= pointer + 8'd1;
            end else begin
              sda_oe <= ~tx[7];
              tx     <= {tx[6:0], 1'b1};
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end

      // Host write is last so it overrides a same-cycle bus write.
      if (host_write && host_ok) regs[host_addr[IDX_W-1:0]] <= host_wdata;
      host_rdata <= host_ok ? regs[host_addr[IDX_W-1:0]] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, write scoreboard,
// table-driven host-port vectors and hand-written bus corner cases.
module tb_i2c_target_regfile;
  localparam int Q  = 15;
  localparam int FL = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_write = 1'b0;
  logic [7:0] host_rdata;
  logic       i2c_wr_pulse;
  logic [7:0] i2c_wr_addr;
  logic [7:0] i2c_wr_data;
  logic       busy;
  wire        sda_line;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_write(host_write),
    .host_rdata(host_rdata), .i2c_wr_pulse(i2c_wr_pulse), .i2c_wr_addr(i2c_wr_addr),
    .i2c_wr_data(i2c_wr_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t wr_q[$];

  always @(negedge clk) begin
    if (reset_n && i2c_wr_pulse) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_pulse_unexpected addr=%0h data=%0h required=none",
                 i2c_wr_addr, i2c_wr_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", {24'd0, i2c_wr_addr}, {24'd0, e.a});
        chk("wr_data", {24'd0, i2c_wr_data}, {24'd0, e.d});
      end
    end
  end

  logic prev_oe = 1'b0;
  int   oe_viol = 0;
  int   oe_cnt  = 0;
  always @(negedge clk) begin
    if (reset_n && (sda_oe !== prev_oe) && scl_m) oe_viol++;
    if (sda_oe) oe_cnt++;
    prev_oe = sda_oe;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // glitch: 0 none, 1 short SCL high pulse while low, 2 short SDA flip while SCL high
  task automatic i2c_bit(input logic b, input int glitch, output logic s);
    if (glitch == 1) begin
      scl_m = 1'b1; wait_clks(FL - 1); scl_m = 1'b0; wait_clks(3);
    end
    sda_m = b;     wait_clks(Q);
    scl_m = 1'b1;  wait_clks(Q);
    s = sda_line;
    if (glitch == 2) begin
      sda_m = ~b; wait_clks(FL - 1); sda_m = b; wait_clks(Q - FL + 1);
    end else wait_clks(Q);
    scl_m = 1'b0;  wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    sda_m = 1'b0; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, input int gkind,
                            output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) i2c_bit(b[7-i], (i == gbit) ? gkind : 0, s);
    i2c_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, 0, s);
      d = {d[6:0], s};
    end
    i2c_bit(nack, 0, s);
  endtask

  typedef struct {int ph; logic wr; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp;} hv_t;
  localparam int NHV = 12;
  hv_t hv[NHV];

  task automatic host_vec(input int idx, input hv_t v);
    @(negedge clk);
    host_addr = v.addr; host_wdata = v.wdata; host_write = v.wr;
    @(negedge clk);
    host_write = 1'b0;
    @(negedge clk);
    chk($sformatf("host_vec%0d", idx), {24'd0, host_rdata}, {24'd0, v.exp});
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < NHV; i++) if (hv[i].ph == p) host_vec(i, hv[i]);
  endtask

  logic [7:0] d;
  logic       ack, s;
  int         snap;

  initial begin
    hv[0]  = '{0, 1'b0, 8'h03, 8'h00, 8'hA5};
    hv[1]  = '{0, 1'b0, 8'h04, 8'h00, 8'h5A};
    hv[2]  = '{0, 1'b0, 8'h0F, 8'h00, 8'h11};
    hv[3]  = '{0, 1'b0, 8'h07, 8'h00, 8'hC3};
    hv[4]  = '{0, 1'b0, 8'h08, 8'h00, 8'h3C};
    hv[5]  = '{0, 1'b0, 8'h05, 8'h00, 8'h6B};
    hv[6]  = '{1, 1'b0, 8'h03, 8'h00, 8'h00};
    hv[7]  = '{1, 1'b0, 8'h0F, 8'h00, 8'h00};
    hv[8]  = '{1, 1'b0, 8'h07, 8'h00, 8'h00};
    hv[9]  = '{1, 1'b1, 8'h02, 8'h77, 8'h77};
    hv[10] = '{1, 1'b1, 8'h00, 8'h9E, 8'h9E};
    hv[11] = '{1, 1'b0, 8'h02, 8'h00, 8'h77};

    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_pulse", {31'd0, i2c_wr_pulse}, 0);
    chk("rst_wr_addr", {24'd0, i2c_wr_addr}, 0);
    chk("rst_wr_data", {24'd0, i2c_wr_data}, 0);
    chk("rst_host_rdata", {24'd0, host_rdata}, 0);

    // 1: pointer write then two data bytes
    i2c_start();
    write_byte(8'hA0, -1, 0, ack); chk("t1_addr_ack", {31'd0, ack}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    write_byte(8'h03, -1, 0, ack); chk("t1_ptr_ack", {31'd0, ack}, 1);
    wr_q.push_back('{8'h03, 8'hA5});
    write_byte(8'hA5, -1, 0, ack); chk("t1_d0_ack", {31'd0, ack}, 1);
    wr_q.push_back('{8'h04, 8'h5A});
    write_byte(8'h5A, -1, 0, ack); chk("t1_d1_ack", {31'd0, ack}, 1);
    i2c_stop();
    wait_clks(5);
    chk("t1_busy_after_stop", {31'd0, busy}, 0);
    chk("t1_wr_q_drained", wr_q.size(), 0);
    chk("t1_wr_addr_held", {24'd0, i2c_wr_addr}, 32'h04);
    chk("t1_wr_data_held", {24'd0, i2c_wr_data}, 32'h5A);

    // 2: pointer, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    write_byte(8'hA0, -1, 0, ack);
    write_byte(8'h03, -1, 0, ack);
    i2c_start();
    write_byte(8'hA1, -1, 0, ack); chk("t2_rd_addr_ack", {31'd0, ack}, 1);
    read_byte(d, 1'b0); chk("t2_rd0", {24'd0, d}, 32'hA5);
    read_byte(d, 1'b1); chk("t2_rd1", {24'd0, d}, 32'h5A);
    wait_clks(Q);
    chk("t2_oe_after_nack", {31'd0, sda_oe}, 0);
    i2c_stop();
    @(negedge clk); host_addr = 8'h05; host_wdata = 8'h6B; host_write = 1'b1;
    @(negedge clk); host_write = 1'b0;
    i2c_start();
    write_byte(8'hA1, -1, 0, ack);
    read_byte(d, 1'b1); chk("t2_ptr_is_5", {24'd0, d}, 32'h6B);
    i2c_stop();

    // 3: foreign address is ignored
    snap = oe_cnt;
    i2c_start();
    write_byte(8'hA2, -1, 0, ack); chk("t3_nack", {31'd0, ack}, 0);
    chk("t3_busy", {31'd0, busy}, 0);
    write_byte(8'h03, -1, 0, ack);
    i2c_stop();
    chk("t3_no_oe", oe_cnt - snap, 0);
    i2c_start();
    write_byte(8'hA0, -1, 0, ack); chk("t3_next_ack", {31'd0, ack}, 1);
    i2c_stop();

    // 4: writes past the last register are acked but dropped
    i2c_start();
    write_byte(8'hA0, -1, 0, ack);
    write_byte(8'h0F, -1, 0, ack);
    wr_q.push_back('{8'h0F, 8'h11});
    write_byte(8'h11, -1, 0, ack); chk("t4_d0_ack", {31'd0, ack}, 1);
    write_byte(8'h22, -1, 0, ack); chk("t4_oob_ack", {31'd0, ack}, 1);
    i2c_stop();
    wait_clks(5);
    chk("t4_wr_q_drained", wr_q.size(), 0);
    i2c_start();
    write_byte(8'hA0, -1, 0, ack);
    write_byte(8'h10, -1, 0, ack);
    i2c_start();
    write_byte(8'hA1, -1, 0, ack);
    read_byte(d, 1'b1); chk("t4_oob_read", {24'd0, d}, 32'hFF);
    i2c_stop();

    // 5: glitches on SCL (low phase) and SDA (high phase)
    i2c_start();
    write_byte(8'hA0, -1, 0, ack);
    write_byte(8'h07, 2, 1, ack); chk("t5_ptr_ack", {31'd0, ack}, 1);
    wr_q.push_back('{8'h07, 8'hC3});
    write_byte(8'hC3, 1, 2, ack); chk("t5_d0_ack", {31'd0, ack}, 1);
    wr_q.push_back('{8'h08, 8'h3C});
    write_byte(8'h3C, 0, 2, ack); chk("t5_d1_ack", {31'd0, ack}, 1);
    chk("t5_busy", {31'd0, busy}, 1);
    i2c_stop();
    wait_clks(5);
    chk("t5_wr_q_drained", wr_q.size(), 0);

    run_phase(0);

    // 6: async reset while driving a '0' read bit
    i2c_start();
    write_byte(8'hA0, -1, 0, ack);
    write_byte(8'h03, -1, 0, ack);
    i2c_start();
    write_byte(8'hA1, -1, 0, ack);
    i2c_bit(1'b1, 0, s); chk("t6_bit7", {31'd0, s}, 1);
    chk("t6_driving0", {31'd0, sda_oe}, 1);
    @(negedge clk); reset_n = 1'b0;
    #1 chk("t6_oe_async", {31'd0, sda_oe}, 0);
    scl_m = 1'b1; wait_clks(Q); sda_m = 1'b1; wait_clks(Q);
    reset_n = 1'b1; wait_clks(3);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_wr_addr", {24'd0, i2c_wr_addr}, 0);
    run_phase(1);
    @(negedge clk); host_addr = 8'h00;
    @(negedge clk); host_addr = 8'h02;
    @(negedge clk); chk("t6_rdata_1clk", {24'd0, host_rdata}, 32'h77);
    i2c_start();
    write_byte(8'hA1, -1, 0, ack); chk("t6_idle_ack", {31'd0, ack}, 1);
    read_byte(d, 1'b1); chk("t6_ptr_reset", {24'd0, d}, 32'h9E);
    i2c_stop();
    wait_clks(5);

    chk("oe_timing", oe_viol, 0);
    chk("final_wr_q", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
